// File: rtl/rf_pkg.sv
// Shared constants, FSM state type, instruction payload and address helpers
// for the register-file operand-fetch stage.
package rf_pkg;

   localparam int unsigned ADDR_W   = 16;
   localparam int unsigned DATA_W   = 64;
   localparam int unsigned OP_W     = 8;
   localparam int unsigned RF_DEPTH = 12;
   localparam int unsigned IDX_W    = 4;

   localparam logic [ADDR_W-1:0] RF_BASE = 16'h0100;
   localparam logic [ADDR_W-1:0] RF_END  = RF_BASE + ADDR_W'(RF_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      HAZARD,
      READ,
      ISSUE
   } state_t;

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [ADDR_W-1:0] dst;
      logic [ADDR_W-1:0] src1;
      logic [ADDR_W-1:0] src2;
   } instr_t;

   function automatic logic in_range(input logic [ADDR_W-1:0] addr);
      return (addr >= RF_BASE) && (addr < RF_END);
   endfunction

   function automatic logic [IDX_W-1:0] addr_to_idx(input logic [ADDR_W-1:0] addr);
      return IDX_W'(addr - RF_BASE);
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one bit per register marks a result still in flight.
// Hazard queries see this cycle's write-back already retired.
import rf_pkg::*;

module rf_scoreboard (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                set_en,
   input  logic [IDX_W-1:0]    set_idx,
   input  logic                clr_en,
   input  logic [IDX_W-1:0]    clr_idx,
   input  logic [IDX_W-1:0]    q_idx1,
   input  logic [IDX_W-1:0]    q_idx2,
   output logic                hazard_c,
   output logic [RF_DEPTH-1:0] busy
);

   localparam int unsigned SPAN = 2 ** IDX_W;

   logic [RF_DEPTH-1:0] set_mask;
   logic [RF_DEPTH-1:0] clr_mask;
   logic [RF_DEPTH-1:0] live;
   logic [SPAN-1:0]     live_ext;

   // Zero-extended view keeps lookups with unused index codes safe.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_en) set_mask = RF_DEPTH'(1) << set_idx;
      if (clr_en) clr_mask = RF_DEPTH'(1) << clr_idx;
      live     = busy & ~clr_mask;
      live_ext = SPAN'(live);
      hazard_c = live_ext[q_idx1] | live_ext[q_idx2];
   end

   // Clear first, then set, so an issue on the write-back edge stays busy.
   always_ff @(posedge clk) begin
      if (!reset_n) busy <= '0;
      else          busy <= live | set_mask;
   end

endmodule

// File: rtl/rf_operand_fetch.sv
// Operand-fetch stage: hazard-checks a decoded instruction against the busy
// scoreboard, reads both sources from the register file and hands them to execute.
import rf_pkg::*;

module rf_operand_fetch (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_valid,
   output logic              i_ready,
   input  logic [OP_W-1:0]   i_op,
   input  logic [ADDR_W-1:0] i_dst,
   input  logic [ADDR_W-1:0] i_src1,
   input  logic [ADDR_W-1:0] i_src2,
   output logic [ADDR_W-1:0] R_addr2,
   output logic [ADDR_W-1:0] R_addr3,
   input  logic [DATA_W-1:0] rData,
   input  logic [DATA_W-1:0] rData2,
   input  logic              wb_we,
   input  logic [ADDR_W-1:0] wb_addr,
   output logic              o_valid,
   input  logic              o_ready,
   output logic [OP_W-1:0]   o_op,
   output logic [ADDR_W-1:0] o_dst,
   output logic [DATA_W-1:0] o_a,
   output logic [DATA_W-1:0] o_b,
   output logic              err_addr
);

   state_t           state;
   instr_t           instr_q;
   logic [IDX_W-1:0] q_idx1;
   logic [IDX_W-1:0] q_idx2;
   logic             hazard_c;
   logic             req_ok_c;
   logic             set_en;
   logic             clr_en;
   logic [RF_DEPTH-1:0] busy;

   assign o_op  = instr_q.op;
   assign o_dst = instr_q.dst;

   assign req_ok_c = in_range(i_dst) && in_range(i_src1) && in_range(i_src2);
   assign set_en   = (state == ISSUE) && o_ready;
   assign clr_en   = wb_we && in_range(wb_addr);

   // In IDLE the offered sources are checked so a clean accept goes straight to READ.
   assign q_idx1 = (state == IDLE) ? addr_to_idx(i_src1) : addr_to_idx(instr_q.src1);
   assign q_idx2 = (state == IDLE) ? addr_to_idx(i_src2) : addr_to_idx(instr_q.src2);

   rf_scoreboard u_sb (
      .clk      (clk),
      .reset_n  (reset_n),
      .set_en   (set_en),
      .set_idx  (addr_to_idx(instr_q.dst)),
      .clr_en   (clr_en),
      .clr_idx  (addr_to_idx(wb_addr)),
      .q_idx1   (q_idx1),
      .q_idx2   (q_idx2),
      .hazard_c (hazard_c),
      .busy     (busy)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         i_ready  <= 1'b1;
         instr_q  <= '0;
         R_addr2  <= RF_BASE;
         R_addr3  <= RF_BASE;
         o_valid  <= 1'b0;
         o_a      <= '0;
         o_b      <= '0;
         err_addr <= 1'b0;
      end else begin
         err_addr <= 1'b0;
         case (state)
            IDLE: begin
               if (i_valid) begin
                  if (!req_ok_c) begin
                     err_addr <= 1'b1;
                  end else begin
                     instr_q <= '{op: i_op, dst: i_dst, src1: i_src1, src2: i_src2};
                     i_ready <= 1'b0;
                     if (hazard_c) begin
                        state <= HAZARD;
                     end else begin
                        state   <= READ;
                        R_addr2 <= i_src1;
                        R_addr3 <= i_src2;
                     end
                  end
               end
            end
            HAZARD: begin
               if (!hazard_c) begin
                  state   <= READ;
                  R_addr2 <= instr_q.src1;
                  R_addr3 <= instr_q.src2;
               end
            end
            READ: begin
               o_a     <= rData;
               o_b     <= rData2;
               o_valid <= 1'b1;
               state   <= ISSUE;
            end
            ISSUE: begin
               if (o_ready) begin
                  o_valid <= 1'b0;
                  i_ready <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rf_operand_fetch.sv
// Directed plus randomized bench for rf_operand_fetch with a register-file
// fixture and an abstract model of register contents and pending results.
module tb_rf_operand_fetch;
   import rf_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        i_valid, i_ready;
   logic [7:0]  i_op;
   logic [15:0] i_dst, i_src1, i_src2;
   logic [15:0] R_addr2, R_addr3;
   logic [63:0] rData, rData2;
   logic        wb_we;
   logic [15:0] wb_addr;
   logic [63:0] wb_data;
   logic        o_valid, o_ready;
   logic [7:0]  o_op;
   logic [15:0] o_dst;
   logic [63:0] o_a, o_b;
   logic        err_addr;

   int checks = 0;
   int errors = 0;

   logic [63:0] mem    [12];
   logic [63:0] exp_rf [12];
   logic [11:0] exp_busy;
   logic [63:0] hold_a, hold_b;

   rf_operand_fetch dut (
      .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .i_ready(i_ready),
      .i_op(i_op), .i_dst(i_dst), .i_src1(i_src1), .i_src2(i_src2),
      .R_addr2(R_addr2), .R_addr3(R_addr3), .rData(rData), .rData2(rData2),
      .wb_we(wb_we), .wb_addr(wb_addr), .o_valid(o_valid), .o_ready(o_ready),
      .o_op(o_op), .o_dst(o_dst), .o_a(o_a), .o_b(o_b), .err_addr(err_addr)
   );

   always #5 clk = ~clk;

   function automatic logic is_reg(input logic [15:0] a);
      return (a >= 16'h0100) && (a <= 16'h010b);
   endfunction

   function automatic int ridx(input logic [15:0] a);
      return int'(a) - 256;
   endfunction

   function automatic logic [15:0] rand_addr();
      if ($urandom_range(0, 9) == 0) begin
         case ($urandom_range(0, 3))
            0:       return 16'h00ff;
            1:       return 16'h010c;
            2:       return 16'h010f;
            default: return 16'hffff;
         endcase
      end
      return 16'h0100 + 16'($urandom_range(0, 11));
   endfunction

   // Register-file fixture: synchronous write, combinational read.
   always @(posedge clk)
      if (wb_we && is_reg(wb_addr)) mem[ridx(wb_addr)] <= wb_data;
   assign rData  = is_reg(R_addr2) ? mem[ridx(R_addr2)] : 64'h0;
   assign rData2 = is_reg(R_addr3) ? mem[ridx(R_addr3)] : 64'h0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wb(input logic [15:0] a, input logic [63:0] d);
      wb_we = 1'b1; wb_addr = a; wb_data = d;
      step();
      wb_we = 1'b0;
      if (is_reg(a)) begin
         exp_rf[ridx(a)]   = d;
         exp_busy[ridx(a)] = 1'b0;
      end
   endtask

   task automatic offer(input logic [7:0] op, input logic [15:0] d,
                        input logic [15:0] s1, input logic [15:0] s2);
      i_valid = 1'b1; i_op = op; i_dst = d; i_src1 = s1; i_src2 = s2;
      step();
      i_valid = 1'b0;
   endtask

   initial begin
      i_valid = 0; i_op = 0; i_dst = 0; i_src1 = 0; i_src2 = 0;
      wb_we = 0; wb_addr = 0; wb_data = 0; o_ready = 0;
      exp_busy = '0;

      // Reset for two edges
      reset_n = 1'b0;
      step(); step();
      reset_n = 1'b1;
      check("rst_i_ready", 64'(i_ready), 64'd1);
      check("rst_o_valid", 64'(o_valid), 64'd0);
      check("rst_raddr2",  64'(R_addr2), 64'h0100);
      check("rst_raddr3",  64'(R_addr3), 64'h0100);
      check("rst_err",     64'(err_addr), 64'd0);
      check("rst_o_a",     o_a, 64'd0);
      check("rst_o_dst",   64'(o_dst), 64'd0);
      check("rst_busy",    64'(dut.u_sb.busy), 64'd0);

      // Simple fetch
      wb(16'h0100, 64'hffff_ffff_ff00_ff00);
      wb(16'h0101, 64'hffff_ffff_ff00_ff01);
      o_ready = 1'b1;
      offer(8'h11, 16'h0102, 16'h0100, 16'h0101);
      check("fetch_i_ready_low", 64'(i_ready), 64'd0);
      check("fetch_valid_early", 64'(o_valid), 64'd0);
      check("fetch_raddr2", 64'(R_addr2), 64'h0100);
      check("fetch_raddr3", 64'(R_addr3), 64'h0101);
      step();
      check("fetch_valid", 64'(o_valid), 64'd1);
      check("fetch_o_a", o_a, 64'hffff_ffff_ff00_ff00);
      check("fetch_o_b", o_b, 64'hffff_ffff_ff00_ff01);
      check("fetch_o_op", 64'(o_op), 64'h11);
      check("fetch_o_dst", 64'(o_dst), 64'h0102);
      step();
      exp_busy[2] = 1'b1;
      check("fetch_done_valid", 64'(o_valid), 64'd0);
      check("fetch_done_ready", 64'(i_ready), 64'd1);
      check("fetch_busy", 64'(dut.u_sb.busy), 64'(exp_busy));

      // RAW hazard on 0x0103
      offer(8'h22, 16'h0103, 16'h0100, 16'h0101);
      step(); step();
      exp_busy[3] = 1'b1;
      o_ready = 1'b0;
      offer(8'h33, 16'h0104, 16'h0103, 16'h0100);
      for (int k = 0; k < 4; k++) begin
         check("haz_state", 64'(dut.state), 64'(HAZARD));
         check("haz_no_valid", 64'(o_valid), 64'd0);
         step();
      end
      wb(16'h0103, 64'hffff_ffff_ff00_ff02);
      check("haz_read_state", 64'(dut.state), 64'(READ));
      step();
      check("haz_valid", 64'(o_valid), 64'd1);
      check("haz_o_a", o_a, 64'hffff_ffff_ff00_ff02);
      check("haz_o_b", o_b, 64'hffff_ffff_ff00_ff00);

      // Backpressure: hold o_ready low for 5 cycles
      hold_a = o_a; hold_b = o_b;
      for (int k = 0; k < 5; k++) begin
         step();
         check("bp_valid", 64'(o_valid), 64'd1);
         check("bp_o_a", o_a, hold_a);
         check("bp_o_b", o_b, hold_b);
         check("bp_i_ready", 64'(i_ready), 64'd0);
         check("bp_busy", 64'(dut.u_sb.busy), 64'(exp_busy));
      end
      o_ready = 1'b1;
      step();
      o_ready = 1'b0;
      exp_busy[4] = 1'b1;
      check("bp_done_valid", 64'(o_valid), 64'd0);
      check("bp_done_busy", 64'(dut.u_sb.busy), 64'(exp_busy));

      // Out-of-range addresses are rejected with a single-cycle pulse
      offer(8'h44, 16'h0105, 16'h0100, 16'h010c);
      check("bad_err", 64'(err_addr), 64'd1);
      check("bad_i_ready", 64'(i_ready), 64'd1);
      check("bad_o_valid", 64'(o_valid), 64'd0);
      step();
      check("bad_err_pulse", 64'(err_addr), 64'd0);
      check("bad_o_valid2", 64'(o_valid), 64'd0);
      check("bad_state", 64'(dut.state), 64'(IDLE));
      offer(8'h45, 16'h00ff, 16'h0100, 16'h0101);
      check("bad_dst_err", 64'(err_addr), 64'd1);
      wb(16'h010c, 64'h1234);
      check("wb_oor_ignored", 64'(dut.u_sb.busy), 64'(exp_busy));

      // Issue and write-back of the same register on one edge
      offer(8'h55, 16'h0105, 16'h0100, 16'h0101);
      step();
      check("same_valid", 64'(o_valid), 64'd1);
      o_ready = 1'b1;
      wb_we = 1'b1; wb_addr = 16'h0105; wb_data = 64'h5555;
      step();
      wb_we = 1'b0; o_ready = 1'b0;
      exp_rf[5] = 64'h5555;
      exp_busy[5] = 1'b1;
      check("same_busy5", 64'(dut.u_sb.busy[5]), 64'd1);
      check("same_busy", 64'(dut.u_sb.busy), 64'(exp_busy));

      // Randomized phase: fill every register, then random instructions
      for (int r = 0; r < 12; r++) wb(16'h0100 + 16'(r), {$urandom, $urandom});
      check("rand_busy_clear", 64'(dut.u_sb.busy), 64'd0);
      for (int n = 0; n < 60; n++) begin
         logic [15:0] s1, s2, d;
         logic [7:0]  op;
         logic        bad, haz;
         s1 = rand_addr(); s2 = rand_addr(); d = rand_addr();
         op = 8'($urandom);
         bad = !(is_reg(s1) && is_reg(s2) && is_reg(d));
         haz = 1'b0;
         if (!bad) haz = exp_busy[ridx(s1)] || exp_busy[ridx(s2)];
         offer(op, d, s1, s2);
         if (bad) begin
            check("r_bad_err", 64'(err_addr), 64'd1);
            check("r_bad_ready", 64'(i_ready), 64'd1);
            step();
            check("r_bad_err_end", 64'(err_addr), 64'd0);
         end else begin
            check("r_err_low", 64'(err_addr), 64'd0);
            check("r_i_ready_low", 64'(i_ready), 64'd0);
            if (haz) begin
               repeat ($urandom_range(1, 3)) begin
                  check("r_haz_state", 64'(dut.state), 64'(HAZARD));
                  check("r_haz_valid", 64'(o_valid), 64'd0);
                  step();
               end
               if (exp_busy[ridx(s1)]) wb(s1, {$urandom, $urandom});
               if (exp_busy[ridx(s2)]) wb(s2, {$urandom, $urandom});
            end else begin
               check("r_valid_early", 64'(o_valid), 64'd0);
            end
            step();
            check("r_valid", 64'(o_valid), 64'd1);
            check("r_o_a", o_a, exp_rf[ridx(s1)]);
            check("r_o_b", o_b, exp_rf[ridx(s2)]);
            check("r_o_op", 64'(o_op), 64'(op));
            check("r_o_dst", 64'(o_dst), 64'(d));
            repeat ($urandom_range(0, 2)) begin
               step();
               check("r_bp_valid", 64'(o_valid), 64'd1);
            end
            o_ready = 1'b1;
            step();
            o_ready = 1'b0;
            exp_busy[ridx(d)] = 1'b1;
            check("r_done_valid", 64'(o_valid), 64'd0);
            check("r_done_ready", 64'(i_ready), 64'd1);
            check("r_busy", 64'(dut.u_sb.busy), 64'(exp_busy));
         end
         if ($urandom_range(0, 1) == 1) wb(16'h0100 + 16'($urandom_range(0, 11)), {$urandom, $urandom});
      end

      // Mid-operation reset drops the instruction and all pending hazards
      offer(8'h66, 16'h0106, 16'h0100, 16'h0101);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      exp_busy = '0;
      check("midrst_state", 64'(dut.state), 64'(IDLE));
      check("midrst_busy", 64'(dut.u_sb.busy), 64'(exp_busy));
      check("midrst_valid", 64'(o_valid), 64'd0);
      check("midrst_o_a", o_a, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
